// File: rtl/word_packer.sv
// Packs RATIO narrow input words into one wide output word, with early flush on in_last.
// Optional output-transfer counter port out_words when WORD_PACKER_STATS_EN is defined.
module word_packer #(
    parameter int IN_W  = 32,
    parameter int RATIO = 2,
    parameter int ORDER = 0,
    localparam int OUT_W  = IN_W * RATIO,
    localparam int LANE_W = $clog2(RATIO),
    localparam int CNT_W  = $clog2(RATIO + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [CNT_W-1:0] out_count
`ifdef WORD_PACKER_STATS_EN
    ,
    output logic [31:0]      out_words
`endif
);

    logic [OUT_W-1:0]  acc;
    logic [OUT_W-1:0]  acc_next;
    logic [LANE_W-1:0] lane_cnt;
    logic [LANE_W-1:0] lane_sel;
    logic              in_fire;
    logic              out_fire;
    logic              last_lane;
    logic              complete;

    // Ready depends only on registered state and the downstream ready.
    assign in_ready  = !out_valid || out_ready;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign last_lane = (lane_cnt == LANE_W'(RATIO - 1));
    assign complete  = in_fire && (last_lane || in_last);

    always_comb begin
        if (ORDER == 0) begin
            lane_sel = lane_cnt;
        end else begin
            lane_sel = LANE_W'(RATIO - 1) - lane_cnt;
        end
    end

    always_comb begin
        acc_next = acc;
        for (int i = 0; i < RATIO; i++) begin
            if (lane_sel == LANE_W'(i)) begin
                acc_next[i*IN_W +: IN_W] = in_data;
            end
        end
    end

    // Accumulation is cleared on completion so a flushed word has zero upper lanes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc      <= '0;
            lane_cnt <= '0;
        end else if (in_fire) begin
            if (complete) begin
                acc      <= '0;
                lane_cnt <= '0;
            end else begin
                acc      <= acc_next;
                lane_cnt <= lane_cnt + LANE_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_data  <= '0;
            out_count <= '0;
        end else if (complete) begin
            out_data  <= acc_next;
            out_count <= CNT_W'(lane_cnt) + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
        end else if (complete) begin
            out_valid <= 1'b1;
        end else if (out_fire) begin
            out_valid <= 1'b0;
        end
    end

`ifdef WORD_PACKER_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_words <= '0;
        end else if (out_fire && (out_words != 32'hFFFF_FFFF)) begin
            out_words <= out_words + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_word_packer.sv
// Bench for word_packer: three instances (32x2 order 0, 32x2 order 1, 8x4 order 0).
module tb_word_packer;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  iv;
    logic [2:0]  il;
    logic [2:0]  ordy;
    logic [2:0]  ir;
    logic [2:0]  ov;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [7:0]  d2;
    logic [63:0] o0;
    logic [63:0] o1;
    logic [31:0] o2;
    logic [1:0]  c0;
    logic [1:0]  c1;
    logic [2:0]  c2;
`ifdef WORD_PACKER_STATS_EN
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] w2;
`endif

    int checks = 0;
    int failures = 0;

    word_packer #(.IN_W(32), .RATIO(2), .ORDER(0)) u0 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
        .in_data(d0), .in_last(il[0]), .out_valid(ov[0]),
        .out_ready(ordy[0]), .out_data(o0), .out_count(c0)
`ifdef WORD_PACKER_STATS_EN
        , .out_words(w0)
`endif
    );

    word_packer #(.IN_W(32), .RATIO(2), .ORDER(1)) u1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
        .in_data(d1), .in_last(il[1]), .out_valid(ov[1]),
        .out_ready(ordy[1]), .out_data(o1), .out_count(c1)
`ifdef WORD_PACKER_STATS_EN
        , .out_words(w1)
`endif
    );

    word_packer #(.IN_W(8), .RATIO(4), .ORDER(0)) u2 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]),
        .in_data(d2), .in_last(il[2]), .out_valid(ov[2]),
        .out_ready(ordy[2]), .out_data(o2), .out_count(c2)
`ifdef WORD_PACKER_STATS_EN
        , .out_words(w2)
`endif
    );

    // Reference model: list of accepted words per instance, packed by lane rule.
    int rat[3]  = '{2, 2, 4};
    int iwid[3] = '{32, 32, 8};
    int ord[3]  = '{0, 1, 0};
    longint unsigned pd[3][8];
    int pn[3];
    bit mv[3];
    logic [255:0] md[3];
    int mc[3];

    typedef struct {
        int          dut;
        bit          v;
        logic [31:0] d;
        bit          last;
        bit          r;
        bit          e_ov;
        bit          e_ir;
        logic [63:0] e_od;
        int          e_oc;
    } vec_t;
    vec_t vecs[$];

    task automatic chk(string nm, logic [255:0] a, logic [255:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, a, e);
        end
    endtask

    function automatic logic [255:0] od_of(int i);
        case (i)
            0: return 256'(o0);
            1: return 256'(o1);
            default: return 256'(o2);
        endcase
    endfunction

    function automatic int oc_of(int i);
        case (i)
            0: return int'(c0);
            1: return int'(c1);
            default: return int'(c2);
        endcase
    endfunction

    task automatic drive(int i, bit v, logic [31:0] d, bit l, bit r);
        iv[i] = v;
        il[i] = l;
        ordy[i] = r;
        case (i)
            0: d0 = d;
            1: d1 = d;
            default: d2 = d[7:0];
        endcase
    endtask

    task automatic idle_all();
        for (int i = 0; i < 3; i++) drive(i, 1'b0, 32'h0, 1'b0, 1'b1);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            pn[i] = 0;
            mv[i] = 1'b0;
            md[i] = '0;
            mc[i] = 0;
        end
    endtask

    task automatic model_step(int i, bit v, longint unsigned d, bit l, bit r);
        bit rdy;
        int lane;
        rdy = !mv[i] || r;
        if (mv[i] && r) mv[i] = 1'b0;
        if (v && rdy) begin
            pd[i][pn[i]] = d;
            pn[i]++;
            if (pn[i] == rat[i] || l) begin
                md[i] = '0;
                for (int k = 0; k < pn[i]; k++) begin
                    lane = (ord[i] == 0) ? k : rat[i] - 1 - k;
                    md[i] = md[i] | (256'(pd[i][k]) << (lane * iwid[i]));
                end
                mc[i] = pn[i];
                mv[i] = 1'b1;
                pn[i] = 0;
            end
        end
    endtask

    task automatic do_reset();
        idle_all();
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic add(int dut, bit v, logic [31:0] d, bit l, bit r,
                       bit e_ov, bit e_ir, logic [63:0] e_od, int e_oc);
        vec_t t;
        t = '{dut, v, d, l, r, e_ov, e_ir, e_od, e_oc};
        vecs.push_back(t);
    endtask

    initial begin
        logic [63:0] got[$];
        logic [63:0] exp_w;
        logic [31:0] dv[3];
        bit vv[3];
        bit lv[3];
        bit rv[3];

        add(0, 1, 32'h11111111, 0, 1, 0, 1, 64'h0, 0);
        add(0, 1, 32'h22222222, 0, 1, 1, 1, 64'h2222222211111111, 2);
        add(0, 0, 32'h0,        0, 1, 0, 1, 64'h2222222211111111, 2);
        add(0, 1, 32'h1,        0, 0, 0, 1, 64'h2222222211111111, 2);
        add(0, 1, 32'h2,        0, 0, 1, 0, 64'h0000000200000001, 2);
        add(0, 1, 32'h3,        0, 0, 1, 0, 64'h0000000200000001, 2);
        add(0, 1, 32'h3,        0, 1, 0, 1, 64'h0000000200000001, 2);
        add(0, 1, 32'h4,        0, 1, 1, 1, 64'h0000000400000003, 2);
        add(0, 0, 32'h0,        0, 1, 0, 1, 64'h0000000400000003, 2);
        add(1, 1, 32'h11111111, 0, 1, 0, 1, 64'h0, 0);
        add(1, 1, 32'h22222222, 0, 1, 1, 1, 64'h1111111122222222, 2);
        add(1, 0, 32'h0,        0, 1, 0, 1, 64'h1111111122222222, 2);
        add(2, 1, 32'hAA,       0, 1, 0, 1, 64'h0, 0);
        add(2, 1, 32'hBB,       1, 1, 1, 1, 64'h0000BBAA, 2);
        add(2, 1, 32'hCC,       1, 1, 1, 1, 64'h000000CC, 1);
        add(2, 1, 32'hDD,       0, 1, 0, 1, 64'h000000CC, 1);
        add(2, 1, 32'hEE,       1, 1, 1, 1, 64'h0000EEDD, 2);
        add(2, 0, 32'h0,        0, 1, 0, 1, 64'h0000EEDD, 2);
        add(2, 1, 32'h01,       0, 1, 0, 1, 64'h0000EEDD, 2);
        add(2, 1, 32'h02,       0, 1, 0, 1, 64'h0000EEDD, 2);
        add(2, 1, 32'h03,       0, 1, 0, 1, 64'h0000EEDD, 2);
        add(2, 1, 32'h04,       0, 1, 1, 1, 64'h04030201, 4);

        idle_all();
        rst = 1'b0;
        #3;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_ov%0d", i), 256'(ov[i]), 256'(0));
            chk($sformatf("rst_ir%0d", i), 256'(ir[i]), 256'(1));
            chk($sformatf("rst_od%0d", i), od_of(i), 256'(0));
            chk($sformatf("rst_oc%0d", i), 256'(oc_of(i)), 256'(0));
        end
        @(posedge clk);
        #1;
        rst = 1'b1;

        foreach (vecs[n]) begin
            idle_all();
            drive(vecs[n].dut, vecs[n].v, vecs[n].d, vecs[n].last, vecs[n].r);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_ov", n), 256'(ov[vecs[n].dut]), 256'(vecs[n].e_ov));
            chk($sformatf("vec%0d_ir", n), 256'(ir[vecs[n].dut]), 256'(vecs[n].e_ir));
            chk($sformatf("vec%0d_od", n), od_of(vecs[n].dut), 256'(vecs[n].e_od));
            chk($sformatf("vec%0d_oc", n), 256'(oc_of(vecs[n].dut)), 256'(vecs[n].e_oc));
        end

        // Continuous stream 1..8 on the 32x2 instance.
        do_reset();
        for (int k = 1; k <= 8; k++) begin
            drive(0, 1'b1, 32'(k), 1'b0, 1'b1);
            @(negedge clk);
            chk($sformatf("stream_ir%0d", k), 256'(ir[0]), 256'(1));
            @(posedge clk);
            #1;
            if (ov[0]) got.push_back(o0);
        end
        idle_all();
        for (int k = 0; k < 4 && got.size() < 4; k++) begin
            @(posedge clk);
            #1;
            if (ov[0]) got.push_back(o0);
        end
        chk("stream_count", 256'(got.size()), 256'(4));
        for (int k = 0; k < 4 && k < got.size(); k++) begin
            exp_w = {32'(2 * k + 2), 32'(2 * k + 1)};
            chk($sformatf("stream_word%0d", k), 256'(got[k]), 256'(exp_w));
        end

        // Reset in the middle of a word.
        do_reset();
        drive(0, 1'b1, 32'hA0A0A0A0, 1'b0, 1'b1);
        @(posedge clk); #1;
        drive(0, 1'b1, 32'hB0B0B0B0, 1'b0, 1'b1);
        @(posedge clk); #1;
        drive(0, 1'b1, 32'h33333333, 1'b0, 1'b1);
        @(posedge clk); #1;
        drive(0, 1'b1, 32'h44444444, 1'b0, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_ov", 256'(ov[0]), 256'(0));
        chk("mid_rst_ir", 256'(ir[0]), 256'(1));
        chk("mid_rst_od", od_of(0), 256'(0));
        chk("mid_rst_oc", 256'(oc_of(0)), 256'(0));
        @(posedge clk); #1;
        chk("rst_hold_ov", 256'(ov[0]), 256'(0));
        rst = 1'b1;
        @(posedge clk); #1;
        drive(0, 1'b1, 32'h55555555, 1'b0, 1'b1);
        @(posedge clk); #1;
        idle_all();
        chk("after_rst_ov", 256'(ov[0]), 256'(1));
        chk("after_rst_od", od_of(0), 256'(64'h5555555544444444));
        chk("after_rst_oc", 256'(oc_of(0)), 256'(2));

`ifdef WORD_PACKER_STATS_EN
        do_reset();
        for (int k = 0; k < 10; k++) begin
            drive(0, 1'b1, 32'(k), 1'b0, 1'b1);
            @(posedge clk); #1;
        end
        idle_all();
        @(posedge clk); #1;
        chk("stats_words", 256'(w0), 256'(5));
        rst = 1'b0;
        #1;
        chk("stats_rst", 256'(w0), 256'(0));
        @(posedge clk); #1;
        rst = 1'b1;
`endif

        // Random traffic against the list-based model.
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < 3; i++) begin
                vv[i] = ($urandom_range(0, 3) != 0);
                lv[i] = ($urandom_range(0, 4) == 0);
                rv[i] = ($urandom_range(0, 2) != 0);
                dv[i] = (iwid[i] == 8) ? ($urandom & 32'hFF) : $urandom;
                drive(i, vv[i], dv[i], lv[i], rv[i]);
            end
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("rnd%0d_ov%0d", cyc, i), 256'(ov[i]), 256'(mv[i]));
                chk($sformatf("rnd%0d_ir%0d", cyc, i), 256'(ir[i]), 256'(!mv[i] || rv[i]));
                chk($sformatf("rnd%0d_od%0d", cyc, i), od_of(i), md[i]);
                chk($sformatf("rnd%0d_oc%0d", cyc, i), 256'(oc_of(i)), 256'(mc[i]));
                model_step(i, vv[i], longint'(dv[i]), lv[i], rv[i]);
            end
            @(posedge clk);
            #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
